tdm_demux8: RTL
===============

Name: tdm_demux8

Overview:
- Serial time-division demultiplexer; the receive-side counterpart of the team's 8:1 channel mux.
- Takes a one-bit-per-beat TDM stream with a frame-sync marker and distributes beat k of each frame to parallel output bit dout[k].
- Presents each completed 8-channel frame as a registered parallel word with a one-cycle valid strobe.
- Tracks frame alignment with a HUNT/LOCKED state machine and flags sync errors.

Parameters:
- NUM_CH, 8, channels (beats) per frame; power of two, minimum 2.
- MISS_LIMIT, 2, consecutive missing frame syncs tolerated in LOCKED before returning to HUNT; minimum 1.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  1  serial TDM data bit; sampled only when din_valid=1.
- din_valid  input  1  beat qualifier; one beat per cycle when high.
- fsync  input  1  frame-start marker; qualified by din_valid; marks the beat carrying slot 0.
- dout  output  NUM_CH  last completed frame; bit k = slot k.
- dout_valid  output  1  one-cycle pulse when dout has been updated.
- slot  output  log2(NUM_CH)  slot index the next valid beat will occupy.
- locked  output  1  high in LOCKED state.
- sync_err  output  1  one-cycle pulse on any alignment error.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State=HUNT.
  - dout=0, dout_valid=0, slot=0, locked=0, sync_err=0.
  - Shadow register=0, miss counter=0.
- Beat definition: only cycles with din_valid=1 are beats. With din_valid=0, all state holds, and dout_valid and sync_err are 0 on the following cycle.
- HUNT:
  - Beats without fsync are discarded.
  - A beat with fsync=1: shadow[0]<=din, slot<=1, state<=LOCKED, miss counter<=0.
- LOCKED, beat with slot=s, s!=0, fsync=0: shadow[s]<=din; slot<=s+1, wrapping to 0 after NUM_CH-1.
- Frame completion (LOCKED, beat at slot=NUM_CH-1):
  - At that edge, dout<={din, shadow[NUM_CH-2:0]}.
  - dout_valid=1 for exactly the next cycle.
  - Latency: last beat edge to dout/dout_valid visible = 1 clock.
- Expected sync (LOCKED, slot=0, fsync=1): normal capture; miss counter<=0.
- Missing sync (LOCKED, slot=0, fsync=0):
  - sync_err pulses; miss counter increments.
  - Capture continues as slot 0 (flywheel).
  - If the incremented count reaches MISS_LIMIT: state<=HUNT, slot<=0, beat discarded.
- Early sync (LOCKED, slot!=0, fsync=1):
  - sync_err pulses.
  - Partial frame discarded; dout unchanged, no dout_valid.
  - Beat taken as slot 0 (shadow[0]<=din, slot<=1); miss counter<=0.
- Shadow register is never cleared between frames; only written slots are meaningful.
- locked is a registered decode of state. sync_err and dout_valid are registered pulses, never asserted in the same cycle as reset release.
- Reset asserted mid-frame: partial frame lost, outputs return to reset values immediately; first frame after reset requires fsync.

Decomposition:
- Shared package tdm_pkg:
  - State enum (HUNT, LOCKED).
  - Function/constant for slot width = clog2(NUM_CH).
  - Default NUM_CH.
- One natural sub-module: tdm_slot_counter (wrapping slot counter with load-to-1 and clear inputs), reusable by the future tdm_mux8 transmitter.
- FSM and capture register stay in the top.

Test Plan:
- Lock and capture: reset, then frame with fsync on first beat and bits 1,0,1,1,0,0,1,0 (slots 0..7) -> dout=8'h4D one cycle after eighth beat, dout_valid high one cycle, locked=1 from second beat.
- Gapped input: same frame with din_valid low for 3 cycles between slots 3 and 4 -> identical dout=8'h4D; slot holds at 4 during gaps; no spurious dout_valid.
- Early sync: locked, fsync at slot 5 -> sync_err one cycle, no dout_valid for partial frame; next 8 beats carrying 8'hA5 -> dout=8'hA5.
- Flywheel/loss: locked, fsync withheld on two consecutive frame boundaries (MISS_LIMIT=2) -> first miss: sync_err, frame still captured; second miss: sync_err, locked=0, slot=0; a later fsync relocks.
- Mid-frame reset: drop rst_n at slot 4 -> all outputs 0 immediately; after release, beats without fsync produce no dout_valid.
- Back-to-back frames: 3 continuous frames 8'h01, 8'h80, 8'hFF -> three dout_valid pulses spaced exactly 8 cycles apart with matching dout.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and sizing helpers for the TDM channel mux/demux family.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

    localparam int unsigned TDM_NUM_CH = 8;

    function automatic int unsigned slot_width(input int unsigned num_ch);
        return (num_ch < 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Wrapping slot index counter with clear and load-to-1 controls.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int unsigned NUM_CH = TDM_NUM_CH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           advance,
    input  logic                           load_one,
    input  logic                           clear,
    output logic [slot_width(NUM_CH)-1:0]  slot
);

    localparam int unsigned         SLOT_W    = slot_width(NUM_CH);
    localparam logic [SLOT_W-1:0]   LAST_SLOT = SLOT_W'(NUM_CH - 1);

    // clear beats load_one beats advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (clear) begin
            slot <= '0;
        end else if (load_one) begin
            slot <= SLOT_W'(1);
        end else if (advance) begin
            slot <= (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);
        end
    end

endmodule

// File: rtl/tdm_demux8.sv
// Serial TDM demultiplexer: frame-sync tracking, shadow capture and parallel word output.
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int unsigned NUM_CH     = TDM_NUM_CH,
    parameter int unsigned MISS_LIMIT = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           din,
    input  logic                           din_valid,
    input  logic                           fsync,
    output logic [NUM_CH-1:0]              dout,
    output logic                           dout_valid,
    output logic [slot_width(NUM_CH)-1:0]  slot,
    output logic                           locked,
    output logic                           sync_err
);

    localparam int unsigned         SLOT_W    = slot_width(NUM_CH);
    localparam logic [SLOT_W-1:0]   LAST_SLOT = SLOT_W'(NUM_CH - 1);
    localparam int unsigned         MISS_W    = $clog2(MISS_LIMIT + 1);
    localparam logic [MISS_W-1:0]   MISS_MAX  = MISS_W'(MISS_LIMIT);

    tdm_state_e          state, state_next;
    logic [MISS_W-1:0]   miss, miss_next, miss_inc;
    logic [NUM_CH-2:0]   shadow, shadow_next;
    logic [NUM_CH-1:0]   dout_next;
    logic                frame_done, err;
    logic                cap_en;
    logic [SLOT_W-1:0]   cap_slot;
    logic                cnt_adv, cnt_load, cnt_clr;

    tdm_slot_counter #(
        .NUM_CH (NUM_CH)
    ) u_slot_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (cnt_adv),
        .load_one (cnt_load),
        .clear    (cnt_clr),
        .slot     (slot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            miss       <= '0;
            shadow     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_next;
            miss       <= miss_next;
            shadow     <= shadow_next;
            dout       <= dout_next;
            dout_valid <= frame_done;
            sync_err   <= err;
        end
    end

    assign locked   = (state == LOCKED);
    assign miss_inc = miss + MISS_W'(1);

    always_comb begin
        state_next  = state;
        miss_next   = miss;
        shadow_next = shadow;
        dout_next   = dout;
        frame_done  = 1'b0;
        err         = 1'b0;
        cap_en      = 1'b0;
        cap_slot    = '0;
        cnt_adv     = 1'b0;
        cnt_load    = 1'b0;
        cnt_clr     = 1'b0;

        unique case (state)
            HUNT: begin
                if (din_valid && fsync) begin
                    cap_en     = 1'b1;
                    cnt_load   = 1'b1;
                    miss_next  = '0;
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (din_valid) begin
                    if (slot == '0) begin
                        if (fsync) begin
                            cap_en    = 1'b1;
                            cnt_adv   = 1'b1;
                            miss_next = '0;
                        end else begin
                            // flywheel through a missing sync until the limit is hit
                            err       = 1'b1;
                            miss_next = miss_inc;
                            if (miss_inc >= MISS_MAX) begin
                                state_next = HUNT;
                                cnt_clr    = 1'b1;
                            end else begin
                                cap_en  = 1'b1;
                                cnt_adv = 1'b1;
                            end
                        end
                    end else if (fsync) begin
                        err       = 1'b1;
                        cap_en    = 1'b1;
                        cnt_load  = 1'b1;
                        miss_next = '0;
                    end else if (slot == LAST_SLOT) begin
                        frame_done = 1'b1;
                        dout_next  = {din, shadow};
                        cnt_adv    = 1'b1;
                    end else begin
                        cap_en   = 1'b1;
                        cap_slot = slot;
                        cnt_adv  = 1'b1;
                    end
                end
            end
        endcase

        for (int unsigned i = 0; i < NUM_CH - 1; i++) begin
            if (cap_en && (cap_slot == SLOT_W'(i))) begin
                shadow_next[i] = din;
            end
        end
    end

endmodule
